// File: rtl/ila_trigger_unit_pkg.sv
// Shared encodings and default widths for the ILA trigger unit.
// Mode and state codes are fixed so that software decoding them stays stable.
package ila_trigger_unit_pkg;

    localparam int TRIG_DATA_WIDTH = 8;
    localparam int TRIG_OCC_WIDTH  = 8;

    localparam logic [1:0] TRIG_MODE_LEVEL  = 2'b00;
    localparam logic [1:0] TRIG_MODE_ENTER  = 2'b01;
    localparam logic [1:0] TRIG_MODE_CHANGE = 2'b10;
    localparam logic [1:0] TRIG_MODE_RSVD   = 2'b11;

    localparam logic [1:0] TRIG_ST_IDLE  = 2'b00;
    localparam logic [1:0] TRIG_ST_WAIT  = 2'b01;
    localparam logic [1:0] TRIG_ST_ARMED = 2'b10;
    localparam logic [1:0] TRIG_ST_FIRED = 2'b11;

endpackage

// File: rtl/ila_trigger_unit_if.sv
// Control, probe and status bundle between the trigger unit and its driver.
// The master drives config/probe inputs; the trigger unit is the slave.
interface ila_trigger_unit_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OCC_WIDTH  = 8
);
    logic                  arm_i;
    logic                  disarm_i;
    logic                  primed_i;
    logic [1:0]            mode_i;
    logic [DATA_WIDTH-1:0] match_value_i;
    logic [DATA_WIDTH-1:0] match_mask_i;
    logic [OCC_WIDTH-1:0]  occurrence_i;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  trigger_o;
    logic [1:0]            state_o;
    logic                  fired_o;

    modport master (
        output arm_i, disarm_i, primed_i, mode_i,
        output match_value_i, match_mask_i, occurrence_i, data_in,
        input  data_o, trigger_o, state_o, fired_o
    );

    modport slave (
        input  arm_i, disarm_i, primed_i, mode_i,
        input  match_value_i, match_mask_i, occurrence_i, data_in,
        output data_o, trigger_o, state_o, fired_o
    );
endinterface

// File: rtl/ila_trigger_unit_trig_compare.sv
// Event detector: masked compare plus previous-sample history for edge modes.
// History is only valid while armed, so the first armed cycle never yields an edge.
import ila_trigger_unit_pkg::*;

module trig_compare #(
    parameter int DATA_WIDTH = TRIG_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  armed,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic [DATA_WIDTH-1:0] mask,
    output logic                  evt
);
    logic [DATA_WIDTH-1:0] prev_data;
    logic                  prev_hit;
    logic                  prev_valid;
    logic                  hit;

    assign hit = ((data ^ value) & mask) == '0;

    always_comb begin
        evt = 1'b0;
        unique case (mode)
            TRIG_MODE_LEVEL:  evt = hit;
            TRIG_MODE_ENTER:  evt = hit & ~prev_hit & prev_valid;
            TRIG_MODE_CHANGE: evt = (|((data ^ prev_data) & mask)) & prev_valid;
            default:          evt = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_data  <= '0;
            prev_hit   <= 1'b0;
            prev_valid <= 1'b0;
        end else if (armed) begin
            prev_data  <= data;
            prev_hit   <= hit;
            prev_valid <= 1'b1;
        end else begin
            prev_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/ila_trigger_unit.sv
// Trigger generator feeding ila_top: arm/prime FSM, Nth-event counter and a
// one-cycle data pipeline so trigger_o lines up with the sample that caused it.
import ila_trigger_unit_pkg::*;

module ila_trigger_unit #(
    parameter int DATA_WIDTH = TRIG_DATA_WIDTH,
    parameter int OCC_WIDTH  = TRIG_OCC_WIDTH
) (
    input logic               clock,
    input logic               reset,
    ila_trigger_unit_if.slave bus
);
    logic [1:0]            state;
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] value_q;
    logic [DATA_WIDTH-1:0] mask_q;
    logic [OCC_WIDTH-1:0]  n_q;
    logic [OCC_WIDTH-1:0]  count;
    logic [OCC_WIDTH-1:0]  n_in;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  trig_q;
    logic                  fired_q;
    logic                  evt;
    logic                  last;

    assign n_in = (bus.occurrence_i == '0) ? OCC_WIDTH'(1) : bus.occurrence_i;
    assign last = (count == n_q - OCC_WIDTH'(1));

    trig_compare #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
        .clock (clock),
        .reset (reset),
        .armed (state == TRIG_ST_ARMED),
        .mode  (mode_q),
        .data  (bus.data_in),
        .value (value_q),
        .mask  (mask_q),
        .evt   (evt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= TRIG_ST_IDLE;
            mode_q  <= '0;
            value_q <= '0;
            mask_q  <= '0;
            n_q     <= '0;
            count   <= '0;
            trig_q  <= 1'b0;
            fired_q <= 1'b0;
        end else begin
            trig_q <= 1'b0;
            if (bus.disarm_i) begin
                state   <= TRIG_ST_IDLE;
                count   <= '0;
                fired_q <= 1'b0;
            end else begin
                unique case (state)
                    TRIG_ST_IDLE, TRIG_ST_FIRED: begin
                        if (bus.arm_i) begin
                            state   <= TRIG_ST_WAIT;
                            mode_q  <= bus.mode_i;
                            value_q <= bus.match_value_i;
                            mask_q  <= bus.match_mask_i;
                            n_q     <= n_in;
                            count   <= '0;
                            fired_q <= 1'b0;
                        end
                    end
                    TRIG_ST_WAIT: begin
                        if (bus.primed_i)
                            state <= TRIG_ST_ARMED;
                    end
                    default: begin
                        // count stops at N_eff-1, so it can never wrap
                        if (evt && last) begin
                            state   <= TRIG_ST_FIRED;
                            trig_q  <= 1'b1;
                            fired_q <= 1'b1;
                        end else if (evt) begin
                            count <= count + OCC_WIDTH'(1);
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            data_q <= '0;
        else
            data_q <= bus.data_in;
    end

    assign bus.data_o    = data_q;
    assign bus.trigger_o = trig_q;
    assign bus.state_o   = state;
    assign bus.fired_o   = fired_q;
endmodule
